spi_cs_sequencer: RTL

SPI_CS_SEQUENCER -- requirements
Module: spi_cs_sequencer

---
 rtl/spi_cs_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spi_cs_sequencer.sv
// Chip-select sequencer wrapped around an AXI-Stream SPI master: frames one command's
// worth of TX words with cs_n setup/hold timing and routes the echoed RX words downstream.
module spi_cs_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int CS_WIDTH   = 1,
    parameter int LEN_WIDTH  = 8,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [CS_WIDTH-1:0]   cmd_cs,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic [DATA_WIDTH-1:0] rx_axis_tdata,
    input  logic                  rx_axis_tvalid,
    output logic                  rx_axis_tready,
    output logic [DATA_WIDTH-1:0] out_axis_tdata,
    output logic                  out_axis_tvalid,
    input  logic                  out_axis_tready,
    output logic                  out_axis_tlast,
    input  logic                  spi_tx_busy,
    output logic [CS_WIDTH-1:0]   cs_n,
    output logic                  busy,
    output logic                  stray_rx
);

    // A zero-length phase leaves after its first cycle, same as a one-cycle phase.
    localparam int SETUP_LAST = (CS_SETUP > 0) ? CS_SETUP - 1 : 0;
    localparam int HOLD_LAST  = (CS_HOLD > 0) ? CS_HOLD - 1 : 0;
    localparam int TIMER_MAX  = (SETUP_LAST > HOLD_LAST) ? SETUP_LAST : HOLD_LAST;
    localparam int TIMER_W    = (TIMER_MAX > 0) ? $clog2(TIMER_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH:0]   tx_cnt;
    logic [LEN_WIDTH:0]   rx_cnt;
    logic [TIMER_W-1:0]   timer;

    logic               in_xfer;
    logic               rx_pass;
    logic               tx_fire;
    logic               rx_fire;
    logic [LEN_WIDTH:0] len_ext;

    assign in_xfer = (state == S_XFER);
    assign rx_pass = (state == S_SETUP) || in_xfer || (state == S_DRAIN);
    assign len_ext = {1'b0, len_q};

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = in_xfer && s_axis_tvalid;
    assign s_axis_tready = in_xfer && m_axis_tready;
    assign tx_fire       = m_axis_tvalid && m_axis_tready;

    // Outside the framed window the RX side is always drained so a stray word never stalls the master.
    assign out_axis_tdata  = rx_axis_tdata;
    assign out_axis_tvalid = rx_pass && rx_axis_tvalid;
    assign out_axis_tlast  = rx_pass && (rx_cnt == len_ext);
    assign rx_axis_tready  = rx_pass ? out_axis_tready : 1'b1;
    assign rx_fire         = out_axis_tvalid && out_axis_tready;

    assign stray_rx = rst_n && !rx_pass && rx_axis_tvalid;
    assign busy     = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every branch below sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cs_n      <= '1;
            cmd_ready <= 1'b0;
            len_q     <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            timer     <= '0;
        end else begin
            if (rx_fire) begin
                rx_cnt <= rx_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        len_q     <= cmd_len;
                        cs_n      <= ~cmd_cs;
                        tx_cnt    <= '0;
                        rx_cnt    <= '0;
                        timer     <= '0;
                        cmd_ready <= 1'b0;
                        state     <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (timer == TIMER_W'(SETUP_LAST)) begin
                        state <= S_XFER;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_XFER: begin
                    if (tx_fire) begin
                        tx_cnt <= tx_cnt + 1'b1;
                        if (tx_cnt == len_ext) begin
                            state <= S_DRAIN;
                        end
                    end
                end

                // Wait for the echo of the final word and for the master to go quiet.
                S_DRAIN: begin
                    if ((rx_cnt == len_ext + 1'b1) && !spi_tx_busy) begin
                        timer <= '0;
                        state <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (timer == TIMER_W'(HOLD_LAST)) begin
                        cs_n      <= '1;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    cs_n      <= '1;
                    cmd_ready <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
